sha3_256_padder: RTL and testbench
==================================

Name: sha3_256_padder

Overview:
- Message-side front end for the SHA3-256 sponge absorber.
- Accepts a byte-granular 64-bit word stream and packs it into rate-sized (1088-bit) blocks.
- Applies SHA3 domain/pad10*1 padding and hands each block to the absorber over a valid/ready handshake.
- Produces the exact block image the absorber XORs into state lanes 0..16.

Parameters:
RATE_WORDS, 17, rate in 64-bit lanes (136 bytes); block width = 64*RATE_WORDS
DOMAIN_BYTE, 8'h06, first pad byte (SHA3 = 0x06; 0x1F gives SHAKE)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input word present
in_ready  output  1  padder can accept a word this cycle
in_data  input  64  message bytes, byte k at bits [8k+7:8k]
in_bytes  input  4  valid byte count 0..8; sampled only with in_last (non-last words always 8)
in_last  input  1  final word of message
blk_valid  output  1  block available
blk_ready  input  1  absorber accepts block
blk_data  output  1088  block; lane i at [64i+63:64i], byte j at [8j+7:8j]
blk_last  output  1  block is final (padded) block of message

Behaviour:
- Reset (async, rst_n=0): state FILL, word index widx=0, buffer all-zero, in_ready=1, blk_valid=0, blk_last=0, blk_data=0.
- States: FILL, EMIT, EXTRA.
- FILL: in_ready=1. On in_valid&in_ready, the word is written to lane widx; bytes at/after in_bytes are masked to zero on a last word.
  - Not last, widx<16: widx++.
  - Not last, widx==16: -> EMIT, blk_last=0.
  - Last: pad position p=8*widx+in_bytes.
    - p<=135: byte p |= DOMAIN_BYTE, byte 135 |= 0x80 (p==135 gives 0x86), blk_last=1, -> EMIT.
    - p==136 (widx==16, 8 bytes): blk_last=0, pad-pending flag set, -> EMIT.
- EMIT: in_ready=0, blk_valid=1; blk_data/blk_last stable until blk_ready. On blk_valid&blk_ready:
  - Pad-pending: buffer <= pad-only block (byte0=DOMAIN_BYTE, byte135=0x80), blk_last=1, clear flag, -> EXTRA.
  - Otherwise: buffer cleared, widx=0, blk_last=0, -> FILL.
- EXTRA: identical to EMIT with blk_last=1; on handshake -> FILL, cleared.
- Latency: block completing on accept at edge N has blk_valid=1 from cycle N+1. Throughput is 17 accepts + 1 emit per full block when blk_ready is held high.
- in_ready and blk_valid are never both 1; there is no input/output overlap.
- in_bytes>8, or in_bytes!=8 on a non-last word, is illegal. Behaviour is undefined; the bench asserts on it.
- in_last with in_bytes=0 at widx=0 is the empty message: one block, byte0=0x06, byte135=0x80.
- blk_ready high while blk_valid=0 has no effect.
- rst_n low mid-block or mid-EMIT discards the partial message immediately (async). No block is emitted.

Test Plan:
- Empty message (in_last=1, in_bytes=0) -> one block: blk_data[7:0]=0x06, [1087:1080]=0x80, all other bits 0, blk_last=1, blk_valid one cycle after accept.
- "abc" (in_data=64'h636261, in_bytes=3, in_last=1) -> blk_data[23:0]=0x636261, [31:24]=0x06, [1087:1080]=0x80, rest 0, blk_last=1.
- 135-byte message (16 words of 0xFF.., last word in_bytes=7) -> single block: bytes 0..134=0xFF, byte135=0x86, blk_last=1.
- 136-byte message (17 full words, last on word 16) -> block1 all message bytes with blk_last=0; then block2 byte0=0x06, byte135=0x80, blk_last=1; in_ready=0 throughout both.
- Backpressure: hold blk_ready=0 for 10 cycles after blk_valid -> blk_data/blk_last unchanged, in_ready=0. Release -> handshake in 1 cycle, then in_ready=1 the following cycle with widx=0.
- Reset mid-operation: rst_n=0 after 9 words accepted -> next cycle in_ready=1, blk_valid=0. A subsequent "abc" message yields exactly the "abc" block above, with no residue.

Source files
------------

// File: rtl/sha3_256_padder.sv
// rtl/sha3_256_padder.sv - SHA3 rate-block packer with domain/pad10*1 padding
module sha3_256_padder #(
    parameter int          RATE_WORDS  = 17,
    parameter logic [7:0]  DOMAIN_BYTE = 8'h06
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [63:0]             in_data,
    input  logic [3:0]              in_bytes,
    input  logic                    in_last,
    output logic                    blk_valid,
    input  logic                    blk_ready,
    output logic [64*RATE_WORDS-1:0] blk_data,
    output logic                    blk_last
);

    localparam int BW = 64 * RATE_WORDS;
    localparam int RB = 8 * RATE_WORDS;
    localparam int WW = $clog2(RATE_WORDS);
    localparam int PW = $clog2(RB + 1);

    typedef enum logic [1:0] {
        FILL,
        EMIT,
        EXTRA
    } state_t;

    state_t         state;
    logic [WW-1:0]  widx;
    logic           pad_pending;
    logic [BW-1:0]  blk_buf;

    logic [63:0]    word_masked;
    logic [PW-1:0]  pad_pos;
    logic           pad_fits;
    logic [BW-1:0]  fill_next;
    logic [BW-1:0]  pad_only;

    assign blk_data = blk_buf;

    // Byte offset of the first pad byte if the current word ends the message
    assign pad_pos  = PW'({widx, 3'b000}) + PW'(in_bytes);
    assign pad_fits = (pad_pos <= PW'(RB - 1));

    // Zero the bytes beyond the valid count on the final word
    always_comb begin
        word_masked = in_data;
        for (int k = 0; k < 8; k++) begin
            if (in_last && (4'(k) >= in_bytes)) begin
                word_masked[8*k +: 8] = 8'h00;
            end
        end
    end

    // Buffer image after writing the accepted word and, on a final word that
    // leaves room, OR-ing in the domain byte and the closing 0x80
    always_comb begin
        fill_next = blk_buf;
        for (int i = 0; i < RATE_WORDS; i++) begin
            if (widx == WW'(i)) begin
                fill_next[64*i +: 64] = word_masked;
            end
        end
        if (in_last && pad_fits) begin
            for (int j = 0; j < RB; j++) begin
                if (pad_pos == PW'(j)) begin
                    fill_next[8*j +: 8] = fill_next[8*j +: 8] | DOMAIN_BYTE;
                end
            end
            fill_next[BW-1 -: 8] = fill_next[BW-1 -: 8] | 8'h80;
        end
    end

    // Padding-only block used when the message exactly filled the previous block
    always_comb begin
        pad_only             = '0;
        pad_only[7:0]        = DOMAIN_BYTE;
        pad_only[BW-1 -: 8]  = pad_only[BW-1 -: 8] | 8'h80;
    end

    // Fill / emit / extra-pad sequencing with registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FILL;
            widx        <= '0;
            pad_pending <= 1'b0;
            blk_buf     <= '0;
            in_ready    <= 1'b1;
            blk_valid   <= 1'b0;
            blk_last    <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (in_valid && in_ready) begin
                        blk_buf <= fill_next;
                        if (in_last) begin
                            in_ready  <= 1'b0;
                            blk_valid <= 1'b1;
                            state     <= EMIT;
                            if (pad_fits) begin
                                blk_last <= 1'b1;
                            end else begin
                                blk_last    <= 1'b0;
                                pad_pending <= 1'b1;
                            end
                        end else if (widx == WW'(RATE_WORDS - 1)) begin
                            in_ready  <= 1'b0;
                            blk_valid <= 1'b1;
                            blk_last  <= 1'b0;
                            state     <= EMIT;
                        end else begin
                            widx <= widx + WW'(1);
                        end
                    end
                end
                EMIT: begin
                    if (blk_ready) begin
                        if (pad_pending) begin
                            blk_buf     <= pad_only;
                            blk_last    <= 1'b1;
                            pad_pending <= 1'b0;
                            state       <= EXTRA;
                        end else begin
                            blk_buf   <= '0;
                            widx      <= '0;
                            blk_last  <= 1'b0;
                            blk_valid <= 1'b0;
                            in_ready  <= 1'b1;
                            state     <= FILL;
                        end
                    end
                end
                EXTRA: begin
                    if (blk_ready) begin
                        blk_buf   <= '0;
                        widx      <= '0;
                        blk_last  <= 1'b0;
                        blk_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= FILL;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha3_256_padder.sv
// tb/tb_sha3_256_padder.sv - scoreboard bench for sha3_256_padder
module tb_sha3_256_padder;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   in_data;
    logic [3:0]    in_bytes;
    logic          in_last;
    logic          blk_valid;
    logic          blk_ready;
    logic [1087:0] blk_data;
    logic          blk_last;

    sha3_256_padder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_bytes  (in_bytes),
        .in_last   (in_last),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_last  (blk_last)
    );

    typedef struct {
        logic [1087:0] data;
        logic          last;
    } blk_t;

    blk_t       exp_q[$];
    logic [7:0] msg [0:399];
    int         msg_len;
    int         total;
    int         bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            assert (in_bytes <= 4'd8 && (in_last || in_bytes == 4'd8))
                else $error("illegal in_bytes %0d last=%0b", in_bytes, in_last);
        end
        if (rst_n) begin
            assert (!(in_ready && blk_valid))
                else $error("in_ready and blk_valid both high");
        end
    end

    // Reference sponge padding over msg[0:msg_len-1]
    task automatic model_push();
        int nblk;
        int r;
        int idx;
        blk_t e;
        nblk = msg_len / 136 + 1;
        for (int b = 0; b < nblk; b++) begin
            e.data = '0;
            e.last = (b == nblk - 1);
            for (int j = 0; j < 136; j++) begin
                idx = b * 136 + j;
                if (idx < msg_len) e.data[8*j +: 8] = msg[idx];
            end
            if (e.last) begin
                r = msg_len - 136 * b;
                e.data[8*r +: 8] = e.data[8*r +: 8] | 8'h06;
                e.data[1087 -: 8] = e.data[1087 -: 8] | 8'h80;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic collect_block(input int hold);
        int   t;
        int   fb;
        blk_t e;
        logic have;
        t = 0;
        while (!blk_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (!blk_valid) begin
            bad++;
            $display("FAIL blk_timeout: blk_valid=%0b required 1", blk_valid);
            return;
        end
        have = (exp_q.size() > 0);
        total++;
        if (!have) begin
            bad++;
            $display("FAIL unexpected_block: got block with last=%0b, required none", blk_last);
        end else begin
            e = exp_q.pop_front();
            total++;
            if (blk_data !== e.data) begin
                bad++;
                fb = -1;
                for (int j = 135; j >= 0; j--) if (blk_data[8*j +: 8] !== e.data[8*j +: 8]) fb = j;
                $display("FAIL blk_data: byte %0d got %h required %h", fb,
                         blk_data[8*fb +: 8], e.data[8*fb +: 8]);
            end
            total++;
            if (blk_last !== e.last) begin
                bad++;
                $display("FAIL blk_last: got %0b required %0b", blk_last, e.last);
            end
            total++;
            if (in_ready !== 1'b0) begin
                bad++;
                $display("FAIL in_ready_during_emit: got %0b required 0", in_ready);
            end
            blk_ready = 1'b0;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                total++;
                if (blk_valid !== 1'b1 || blk_data !== e.data || blk_last !== e.last || in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL hold_stable: cycle %0d valid=%0b last=%0b ready=%0b required 1/%0b/0",
                             h, blk_valid, blk_last, in_ready, e.last);
                end
            end
        end
        blk_ready = 1'b1;
        @(negedge clk);
        blk_ready = 1'b0;
        total++;
        if ((in_ready ^ blk_valid) !== 1'b1) begin
            bad++;
            $display("FAIL one_side_active: in_ready=%0b blk_valid=%0b required exactly one", in_ready, blk_valid);
        end
        if (have && e.last) begin
            total++;
            if (in_ready !== 1'b1 || blk_valid !== 1'b0) begin
                bad++;
                $display("FAIL ready_after_last: in_ready=%0b blk_valid=%0b required 1/0", in_ready, blk_valid);
            end
        end
    endtask

    task automatic send_word(input logic [63:0] d, input logic [3:0] nb, input logic last);
        int t;
        t = 0;
        while (!in_ready && t < 400) begin
            if (blk_valid) collect_block(0);
            else @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
            return;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_bytes = nb;
        in_last  = last;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_bytes = 4'd8;
        in_data  = {$urandom, $urandom};
    endtask

    task automatic send_message();
        int          nw;
        int          idx;
        logic [63:0] d;
        logic [3:0]  nb;
        model_push();
        nw = (msg_len == 0) ? 1 : (msg_len + 7) / 8;
        for (int w = 0; w < nw; w++) begin
            d = {$urandom, $urandom};
            for (int k = 0; k < 8; k++) begin
                idx = 8 * w + k;
                if (idx < msg_len) d[8*k +: 8] = msg[idx];
            end
            nb = (w == nw - 1) ? 4'(msg_len - 8 * w) : 4'd8;
            send_word(d, nb, w == nw - 1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %0b required 1", in_ready); end
        total++;
        if (blk_valid !== 1'b0) begin bad++; $display("FAIL reset_blk_valid: got %0b required 0", blk_valid); end
        total++;
        if (blk_last !== 1'b0) begin bad++; $display("FAIL reset_blk_last: got %0b required 0", blk_last); end
        total++;
        if (blk_data !== '0) begin bad++; $display("FAIL reset_blk_data: got nonzero required 0"); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_empty();
        msg_len = 0;
        send_message();
        total++;
        if (blk_valid !== 1'b1) begin
            bad++;
            $display("FAIL empty_latency: blk_valid=%0b required 1 one cycle after accept", blk_valid);
        end
        collect_block(0);
    endtask

    task automatic test_abc();
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        msg_len = 3;
        send_message();
        collect_block(0);
    endtask

    task automatic test_135();
        for (int i = 0; i < 135; i++) msg[i] = 8'hFF;
        msg_len = 135;
        send_message();
        collect_block(0);
    endtask

    task automatic test_136();
        for (int i = 0; i < 136; i++) msg[i] = 8'(i + 1);
        msg_len = 136;
        send_message();
        collect_block(0);
        collect_block(0);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 20; i++) msg[i] = 8'($urandom);
        msg_len = 20;
        send_message();
        collect_block(10);
    endtask

    task automatic test_back_to_back();
        int n;
        for (int i = 0; i < 300; i++) msg[i] = 8'($urandom);
        msg_len = 300;
        send_message();
        n = 0;
        while (exp_q.size() > 0 && n < 5) begin
            collect_block(0);
            n++;
        end
    endtask

    task automatic test_reset_mid();
        for (int w = 0; w < 9; w++) send_word({$urandom, $urandom}, 4'd8, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1 || blk_valid !== 1'b0 || blk_data !== '0) begin
            bad++;
            $display("FAIL mid_reset: in_ready=%0b blk_valid=%0b required 1/0 with cleared data", in_ready, blk_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_abc();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain: %0d blocks left required 0", exp_q.size());
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_bytes  = 4'd8;
        in_last   = 1'b0;
        blk_ready = 1'b0;
        test_reset();
        test_empty();
        test_abc();
        test_135();
        test_136();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
